// File: rtl/present_pkg.sv
// Shared constants, FSM state type and S-box helper for the PRESENT encryption core.
// Define PRESENT_KEY128_EN to build the 128-bit key variant; the default is 80-bit.
package present_pkg;

  localparam int PRESENT_ROUNDS = 31;
  localparam int BLOCK_W        = 64;
  localparam int KEY80_W        = 80;
  localparam int KEY128_W       = 128;

`ifdef PRESENT_KEY128_EN
  localparam int KEY_W = KEY128_W;
`else
  localparam int KEY_W = KEY80_W;
`endif

  // Nibble n of this constant is S(n): C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2.
  localparam logic [63:0] SBOX_TABLE = 64'h2174_8FE3_DA09_B65C;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FINAL = 2'd2
  } present_state_t;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    return SBOX_TABLE[{x, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/present_pbox.sv
// PRESENT forward bit permutation: bit i moves to 16*i mod 63, bit 63 stays put.
module present_pbox (
  input  logic [63:0] data,
  output logic [63:0] perm
);

  for (genvar i = 0; i < 63; i++) begin : g_perm
    assign perm[(16 * i) % 63] = data[i];
  end

  assign perm[63] = data[63];

endmodule

// File: rtl/present_enc_core.sv
// Iterative PRESENT block encryptor, one round per clock.
// Key width selected by PRESENT_KEY128_EN (undefined: 80-bit key schedule).
module present_enc_core
  import present_pkg::*;
#(
  parameter int ROUNDS = PRESENT_ROUNDS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [63:0]  idat,
  input  logic [127:0] key,
  output logic         ready,
  output logic         done,
  output logic [63:0]  odat
);

  localparam logic [4:0] LAST_ROUND = 5'(ROUNDS);

  present_state_t fsm, fsm_next;

  logic [63:0]      blk;
  logic [63:0]      mixed;
  logic [63:0]      subst;
  logic [63:0]      perm;
  logic [KEY_W-1:0] kreg;
  logic [KEY_W-1:0] krot;
  logic [KEY_W-1:0] kreg_next;
  logic [4:0]       rnd;
  logic             last;

  assign mixed = blk ^ kreg[KEY_W-1 -: 64];
  assign last  = (rnd == LAST_ROUND);

  for (genvar i = 0; i < 16; i++) begin : g_sbox
    assign subst[4*i +: 4] = sbox(mixed[4*i +: 4]);
  end

  present_pbox u_pbox (
    .data (subst),
    .perm (perm)
  );

`ifdef PRESENT_KEY128_EN
  always_comb begin
    krot                = {kreg[66:0], kreg[127:67]};
    kreg_next           = krot;
    kreg_next[127:124]  = sbox(krot[127:124]);
    kreg_next[123:120]  = sbox(krot[123:120]);
    kreg_next[66:62]    = krot[66:62] ^ rnd;
  end
`else
  logic unused_key;
  assign unused_key = ^key[127:80];

  always_comb begin
    krot              = {kreg[18:0], kreg[79:19]};
    kreg_next         = krot;
    kreg_next[79:76]  = sbox(krot[79:76]);
    kreg_next[19:15]  = krot[19:15] ^ rnd;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm <= IDLE;
    end else begin
      fsm <= fsm_next;
    end
  end

  always_comb begin
    fsm_next = fsm;
    ready    = 1'b0;
    done     = 1'b0;
    case (fsm)
      IDLE: begin
        ready = 1'b1;
        if (start) fsm_next = RUN;
      end
      RUN: begin
        if (last) fsm_next = FINAL;
      end
      FINAL: begin
        done     = 1'b1;
        fsm_next = IDLE;
      end
      default: fsm_next = IDLE;
    endcase
  end

  // odat is captured from the last round's next-state values so that it is
  // already valid during the FINAL cycle, when done is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk  <= '0;
      kreg <= '0;
      rnd  <= '0;
      odat <= '0;
    end else begin
      case (fsm)
        IDLE: begin
          if (start) begin
            blk  <= idat;
            kreg <= key[KEY_W-1:0];
            rnd  <= 5'd1;
          end
        end
        RUN: begin
          blk  <= perm;
          kreg <= kreg_next;
          rnd  <= rnd + 5'd1;
          if (last) odat <= perm ^ kreg_next[KEY_W-1 -: 64];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_present_enc_core.sv
// Directed-vector bench for present_enc_core: published PRESENT vectors plus
// start-flooding, mid-run reset and back-to-back sequences.
module tb_present_enc_core;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [63:0]  idat = '0;
  logic [127:0] key = '0;
  logic         ready;
  logic         done;
  logic [63:0]  odat;

  int errors = 0;
  int checks = 0;
  longint unsigned cyc = 0;

  typedef struct {
    logic [63:0]  pt;
    logic [127:0] k;
    logic [63:0]  ct;
  } vec_t;

  vec_t vecs[$];

  present_enc_core #(.ROUNDS(31)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .idat  (idat),
    .key   (key),
    .ready (ready),
    .done  (done),
    .odat  (odat)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string what, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", what, act, exp);
    end
  endtask

  task automatic check_num(input string what, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", what, act, exp);
    end
  endtask

  // Called at a negedge; drives one start cycle then scrambles the inputs.
  task automatic launch(input logic [63:0] pt, input logic [127:0] k, output longint unsigned t0);
    idat  = pt;
    key   = k;
    start = 1'b1;
    t0    = cyc;
    @(negedge clk);
    start = 1'b0;
    idat  = {$urandom, $urandom};
    key   = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_done(output longint unsigned t1, output bit ok);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    ok = (done === 1'b1);
    t1 = cyc;
  endtask

  task automatic run_vec(input int idx, input string tag);
    longint unsigned t0, t1;
    bit ok;
    launch(vecs[idx].pt, vecs[idx].k, t0);
    wait_done(t1, ok);
    check_num({tag, " done seen"}, longint'(ok), 1);
    check_num({tag, " latency"}, longint'(t1 - t0), 32);
    check_val({tag, " odat"}, odat, vecs[idx].ct);
    @(negedge clk);
    check_val({tag, " done pulse width"}, 64'(done), 64'd0);
    check_val({tag, " ready after done"}, 64'(ready), 64'd1);
    check_val({tag, " odat held"}, odat, vecs[idx].ct);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    longint unsigned t0, t1, t2, t3;
    bit ok;
    int ndone;
    int nv;

`ifdef PRESENT_KEY128_EN
    vecs.push_back('{64'h0, 128'h0, 64'h96DB702A2E6900AF});
`else
    vecs.push_back('{64'h0, 128'h0, 64'h5579C1387B228445});
    vecs.push_back('{64'h0, {48'h0, 80'hFFFFFFFFFFFFFFFFFFFF}, 64'hE72C46C0F5945049});
    vecs.push_back('{64'hFFFFFFFFFFFFFFFF, 128'h0, 64'hA112FFC72F68417B});
    vecs.push_back('{64'hFFFFFFFFFFFFFFFF, {48'h0, 80'hFFFFFFFFFFFFFFFFFFFF}, 64'h3333DCD3213210D2});
    // upper key bits must be ignored in 80-bit mode
    vecs.push_back('{64'h0, {48'hA5A55A5AF00D, 80'h0}, 64'h5579C1387B228445});
`endif
    nv = vecs.size();

    repeat (3) @(negedge clk);
    check_val("reset ready", 64'(ready), 64'd1);
    check_val("reset done", 64'(done), 64'd0);
    check_val("reset odat", odat, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("post-reset ready", 64'(ready), 64'd1);

    for (int i = 0; i < nv; i++) begin
      run_vec(i, $sformatf("vec%0d", i));
    end

    // start held high through a whole block, including the done cycle
    idat  = vecs[0].pt;
    key   = vecs[0].k;
    start = 1'b1;
    ndone = 0;
    t1    = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) begin
        idat = vecs[(nv > 1) ? 1 : 0].pt ^ 64'h1;
        key  = vecs[(nv > 1) ? 1 : 0].k;
      end
      if (done === 1'b1) begin
        ndone++;
        t1 = longint'(n);
        check_val("flood odat", odat, vecs[0].ct);
      end
      if (n >= 33) start = 1'b0;
    end
    check_num("flood done count", ndone, 1);
    check_num("flood done cycle", longint'(t1), 32);
    check_val("flood no second accept", 64'(ready), 64'd1);

    // start during the done cycle is dropped
    launch(vecs[(nv > 2) ? 2 : 0].pt, vecs[(nv > 2) ? 2 : 0].k, t0);
    wait_done(t1, ok);
    check_num("done-cycle start: done seen", longint'(ok), 1);
    idat  = vecs[0].pt ^ 64'h5;
    key   = vecs[0].k;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check_val("done-cycle start ignored", 64'(ready), 64'd1);

    // asynchronous reset in the middle of round 10
    launch(vecs[(nv > 3) ? 3 : 0].pt, vecs[(nv > 3) ? 3 : 0].k, t0);
    repeat (9) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_val("mid-reset ready", 64'(ready), 64'd1);
    check_val("mid-reset done", 64'(done), 64'd0);
    check_val("mid-reset odat", odat, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    check_num("aborted run done count", ndone, 0);
    check_val("aborted run odat", odat, 64'd0);
    run_vec((nv > 1) ? 1 : 0, "after-reset");

    // back-to-back: second start in the first IDLE cycle after done
    launch(vecs[0].pt, vecs[0].k, t0);
    wait_done(t1, ok);
    check_val("b2b first odat", odat, vecs[0].ct);
    @(negedge clk);
    launch(vecs[nv - 1].pt ^ ((nv > 1) ? 64'h0 : 64'h0), vecs[nv - 1].k, t2);
    wait_done(t3, ok);
    check_num("b2b done seen", longint'(ok), 1);
    check_num("b2b done spacing", longint'(t3 - t1), 33);
    check_val("b2b second odat", odat, vecs[nv - 1].ct);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
